// File: rtl/axis_broadcaster_pkg.sv
// Shared sizing helpers for the buffered AXI-Stream broadcaster and its per-output FIFOs.
package axis_broadcaster_pkg;

    localparam int LAST_BITS = 1;

    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Each FIFO entry carries {tlast, tuser, tdata}.
    function automatic int payload_width(input int bytes, input int user_bits);
        return LAST_BITS + user_bits + bytes * 8;
    endfunction

endpackage

// File: rtl/axis_broadcaster_fifo.sv
// Single-clock first-word-fall-through FIFO with extra-MSB pointers and a registered fill level.
module axis_broadcaster_fifo
    import axis_broadcaster_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [WIDTH-1:0]              wr_data,
    output logic                          full,
    input  logic                          rd_en,
    output logic [WIDTH-1:0]              rd_data,
    output logic                          empty,
    output logic [level_width(DEPTH)-1:0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int LW = level_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW-1:0]    wr_ptr_d, rd_ptr_d;
    logic [LW-1:0]    level_q;
    logic             do_wr, do_rd;

    assign full    = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                     (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign do_wr   = wr_en & ~full;
    assign do_rd   = rd_en & ~empty;
    assign rd_data = mem[rd_ptr_q[AW-1:0]];
    assign level   = level_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_rd) rd_ptr_d = rd_ptr_q + PW'(1);
    end

    // NOTE: storage has no reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_q[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= LW'(wr_ptr_d - rd_ptr_d);
        end
    end

endmodule

// File: rtl/axis_broadcaster_buffered.sv
// One AXI-Stream input copied to NUM_STREAMS outputs, each decoupled by its own FIFO;
// the output enable mask is captured at packet start and all-masked packets are dropped and counted.
module axis_broadcaster_buffered
    import axis_broadcaster_pkg::*;
#(
    parameter int AXIS_BYTES     = 1,
    parameter int AXIS_USER_BITS = 1,
    parameter int NUM_STREAMS    = 2,
    parameter int DEPTH          = 4
) (
    input  logic                                      clk,
    input  logic                                      aresetn,
    output logic                                      axis_i_tready,
    input  logic                                      axis_i_tvalid,
    input  logic                                      axis_i_tlast,
    input  logic [AXIS_BYTES*8-1:0]                   axis_i_tdata,
    input  logic [AXIS_USER_BITS-1:0]                 axis_i_tuser,
    input  logic [NUM_STREAMS-1:0]                    en_mask,
    input  logic [NUM_STREAMS-1:0]                    axis_o_tready,
    output logic [NUM_STREAMS-1:0]                    axis_o_tvalid,
    output logic [NUM_STREAMS-1:0]                    axis_o_tlast,
    output logic [NUM_STREAMS*AXIS_BYTES*8-1:0]       axis_o_tdata,
    output logic [NUM_STREAMS*AXIS_USER_BITS-1:0]     axis_o_tuser,
    output logic [NUM_STREAMS*level_width(DEPTH)-1:0] fifo_level,
    output logic [15:0]                               drop_count
);

    localparam int DW = AXIS_BYTES * 8;
    localparam int UW = AXIS_USER_BITS;
    localparam int PW = payload_width(AXIS_BYTES, AXIS_USER_BITS);
    localparam int LW = level_width(DEPTH);

    logic                   run_q;
    logic                   in_packet_q;
    logic [NUM_STREAMS-1:0] mask_q;
    logic [NUM_STREAMS-1:0] eff_mask;
    logic [NUM_STREAMS-1:0] full, empty, wr_en;
    logic [15:0]            drop_count_q;
    logic                   in_hs;
    logic [PW-1:0]          wr_payload;

    // run_q holds the input closed while reset is asserted and until the first clock after release.
    assign eff_mask      = in_packet_q ? mask_q : en_mask;
    assign axis_i_tready = run_q & (&(~eff_mask | ~full));
    assign in_hs         = axis_i_tvalid & axis_i_tready;
    assign wr_en         = {NUM_STREAMS{in_hs}} & eff_mask;
    assign wr_payload    = {axis_i_tlast, axis_i_tuser, axis_i_tdata};
    assign drop_count    = drop_count_q;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            run_q        <= 1'b0;
            in_packet_q  <= 1'b0;
            mask_q       <= '0;
            drop_count_q <= '0;
        end else begin
            run_q <= 1'b1;
            if (in_hs) begin
                if (!in_packet_q) begin
                    mask_q <= en_mask;
                    if (en_mask == '0 && drop_count_q != 16'hFFFF)
                        drop_count_q <= drop_count_q + 16'd1;
                end
                in_packet_q <= ~axis_i_tlast;
            end
        end
    end

    for (genvar i = 0; i < NUM_STREAMS; i++) begin : g_out
        logic [PW-1:0] rd_payload;

        axis_broadcaster_fifo #(
            .WIDTH (PW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (aresetn),
            .wr_en   (wr_en[i]),
            .wr_data (wr_payload),
            .full    (full[i]),
            .rd_en   (axis_o_tready[i]),
            .rd_data (rd_payload),
            .empty   (empty[i]),
            .level   (fifo_level[i*LW +: LW])
        );

        assign axis_o_tvalid[i]         = ~empty[i];
        assign axis_o_tlast[i]          = rd_payload[PW-1];
        assign axis_o_tuser[i*UW +: UW] = rd_payload[DW +: UW];
        assign axis_o_tdata[i*DW +: DW] = rd_payload[DW-1:0];
    end

endmodule

// File: tb/tb_axis_broadcaster_buffered.sv
// Directed scenario bench for axis_broadcaster_buffered (2 streams, 4-deep FIFOs, 8-bit data, 1-bit user).
module tb_axis_broadcaster_buffered;

    logic        clk = 1'b0;
    logic        aresetn = 1'b1;
    logic        i_tready;
    logic        i_tvalid = 1'b0;
    logic        i_tlast = 1'b0;
    logic [7:0]  i_tdata = 8'h00;
    logic        i_tuser = 1'b0;
    logic [1:0]  en_mask = 2'b00;
    logic [1:0]  o_tready = 2'b00;
    logic [1:0]  o_tvalid, o_tlast, o_tuser;
    logic [15:0] o_tdata;
    logic [5:0]  fifo_level;
    logic [15:0] drop_count;

    int errors = 0;
    int checks = 0;

    // Output beats as {tlast, tuser, tdata}.
    logic [9:0] got0[$];
    logic [9:0] got1[$];

    always #5 clk = ~clk;

    axis_broadcaster_buffered #(
        .AXIS_BYTES     (1),
        .AXIS_USER_BITS (1),
        .NUM_STREAMS    (2),
        .DEPTH          (4)
    ) dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .axis_i_tready (i_tready),
        .axis_i_tvalid (i_tvalid),
        .axis_i_tlast  (i_tlast),
        .axis_i_tdata  (i_tdata),
        .axis_i_tuser  (i_tuser),
        .en_mask       (en_mask),
        .axis_o_tready (o_tready),
        .axis_o_tvalid (o_tvalid),
        .axis_o_tlast  (o_tlast),
        .axis_o_tdata  (o_tdata),
        .axis_o_tuser  (o_tuser),
        .fifo_level    (fifo_level),
        .drop_count    (drop_count)
    );

    // Output handshakes are stable mid-cycle, so record them on the falling edge.
    always @(negedge clk) begin
        if (aresetn) begin
            if (o_tvalid[0] && o_tready[0]) got0.push_back({o_tlast[0], o_tuser[0], o_tdata[7:0]});
            if (o_tvalid[1] && o_tready[1]) got1.push_back({o_tlast[1], o_tuser[1], o_tdata[15:8]});
        end
    end

    function automatic bit same(input logic [9:0] a[$], input logic [9:0] b[$]);
        if (a.size() != b.size()) return 1'b0;
        foreach (a[k]) if (a[k] !== b[k]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Presents one beat, waits (bounded) for acceptance, returns 1 ns after the accepting edge.
    task automatic drive_beat(input logic [7:0] d, input logic last, input logic user);
        int n = 0;
        i_tvalid = 1'b1;
        i_tdata  = d;
        i_tlast  = last;
        i_tuser  = user;
        #1;
        while (i_tready !== 1'b1 && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if (i_tready !== 1'b1) begin
            errors++;
            $display("FAIL beat_accept: data %h tready %b required 1", d, i_tready);
        end
        @(posedge clk);
        #1;
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
    endtask

    task automatic test_reset();
        #2 aresetn = 1'b0;
        #1;
        checks++;
        if (i_tready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %b want 0", i_tready); end
        checks++;
        if (o_tvalid !== 2'b00) begin errors++; $display("FAIL reset_tvalid: got %b want 00", o_tvalid); end
        checks++;
        if (fifo_level !== 6'd0) begin errors++; $display("FAIL reset_level: got %h want 0", fifo_level); end
        checks++;
        if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop: got %h want 0", drop_count); end
        #19 aresetn = 1'b1;
        cyc();
        checks++;
        if (i_tready !== 1'b1) begin errors++; $display("FAIL release_tready: got %b want 1", i_tready); end
    endtask

    task automatic test_basic();
        logic [9:0] exp[$];
        en_mask  = 2'b11;
        o_tready = 2'b11;
        got0.delete();
        got1.delete();
        drive_beat(8'h11, 1'b0, 1'b0);
        checks++;
        if (o_tvalid !== 2'b11 || o_tdata !== 16'h1111 || o_tlast !== 2'b00) begin
            errors++; $display("FAIL basic_first: valid %b data %h last %b want 11 1111 00", o_tvalid, o_tdata, o_tlast);
        end
        drive_beat(8'h22, 1'b0, 1'b0);
        checks++;
        if (fifo_level !== {3'd1, 3'd1}) begin errors++; $display("FAIL basic_level: got %h want 09", fifo_level); end
        drive_beat(8'h33, 1'b1, 1'b0);
        checks++;
        if (o_tdata !== 16'h3333 || o_tlast !== 2'b11) begin
            errors++; $display("FAIL basic_last: data %h last %b want 3333 11", o_tdata, o_tlast);
        end
        repeat (3) cyc();
        checks++;
        if (fifo_level !== 6'd0 || o_tvalid !== 2'b00) begin
            errors++; $display("FAIL basic_drain: level %h valid %b want 0 00", fifo_level, o_tvalid);
        end
        exp = '{10'h011, 10'h022, 10'h233};
        checks++;
        if (!same(got0, exp)) begin errors++; $display("FAIL basic_s0: got %p want %p", got0, exp); end
        checks++;
        if (!same(got1, exp)) begin errors++; $display("FAIL basic_s1: got %p want %p", got1, exp); end
    endtask

    task automatic test_stall_isolation();
        logic [9:0] exp[$];
        en_mask  = 2'b11;
        o_tready = 2'b01;
        got0.delete();
        got1.delete();
        for (int b = 1; b <= 4; b++) drive_beat(8'(b), 1'b0, 1'b0);
        i_tvalid = 1'b1;
        i_tdata  = 8'h05;
        #1;
        checks++;
        if (i_tready !== 1'b0) begin errors++; $display("FAIL stall_tready: got %b want 0", i_tready); end
        checks++;
        if (fifo_level[5:3] !== 3'd4) begin errors++; $display("FAIL stall_level1: got %0d want 4", fifo_level[5:3]); end
        @(posedge clk);
        #1;
        checks++;
        if (i_tready !== 1'b0) begin errors++; $display("FAIL stall_hold: got %b want 0", i_tready); end
        checks++;
        if (got0.size() != 4) begin errors++; $display("FAIL stall_s0_flow: got %0d beats want 4", got0.size()); end
        o_tready = 2'b11;
        drive_beat(8'h05, 1'b0, 1'b0);
        drive_beat(8'h06, 1'b1, 1'b0);
        repeat (8) cyc();
        exp = '{10'h001, 10'h002, 10'h003, 10'h004, 10'h005, 10'h206};
        checks++;
        if (!same(got0, exp)) begin errors++; $display("FAIL stall_s0: got %p want %p", got0, exp); end
        checks++;
        if (!same(got1, exp)) begin errors++; $display("FAIL stall_s1: got %p want %p", got1, exp); end
    endtask

    task automatic test_mask_latch();
        logic [9:0] exp0[$];
        logic [9:0] exp1[$];
        o_tready = 2'b11;
        got0.delete();
        got1.delete();
        en_mask = 2'b01;
        drive_beat(8'hA1, 1'b0, 1'b0);
        en_mask = 2'b10;
        drive_beat(8'hA2, 1'b0, 1'b0);
        drive_beat(8'hA3, 1'b1, 1'b0);
        drive_beat(8'hB1, 1'b1, 1'b0);
        repeat (4) cyc();
        exp0 = '{10'h0A1, 10'h0A2, 10'h2A3};
        exp1 = '{10'h2B1};
        checks++;
        if (!same(got0, exp0)) begin errors++; $display("FAIL mask_s0: got %p want %p", got0, exp0); end
        checks++;
        if (!same(got1, exp1)) begin errors++; $display("FAIL mask_s1: got %p want %p", got1, exp1); end
    endtask

    task automatic test_drop();
        en_mask  = 2'b00;
        o_tready = 2'b11;
        got0.delete();
        got1.delete();
        for (int p = 0; p < 2; p++)
            for (int b = 0; b < 4; b++) drive_beat(8'(8'hD0 + b), (b == 3), 1'b0);
        cyc();
        checks++;
        if (drop_count !== 16'd2) begin errors++; $display("FAIL drop_count: got %0d want 2", drop_count); end
        checks++;
        if (got0.size() != 0 || got1.size() != 0) begin
            errors++; $display("FAIL drop_output: got %0d/%0d beats want 0/0", got0.size(), got1.size());
        end
        force dut.drop_count_q = 16'hFFFE;
        #1;
        release dut.drop_count_q;
        #1;
        checks++;
        if (drop_count !== 16'hFFFE) begin errors++; $display("FAIL drop_preset: got %h want fffe", drop_count); end
        drive_beat(8'hE0, 1'b1, 1'b0);
        checks++;
        if (drop_count !== 16'hFFFF) begin errors++; $display("FAIL drop_reach_max: got %h want ffff", drop_count); end
        drive_beat(8'hE1, 1'b1, 1'b0);
        drive_beat(8'hE2, 1'b1, 1'b0);
        checks++;
        if (drop_count !== 16'hFFFF) begin errors++; $display("FAIL drop_saturate: got %h want ffff", drop_count); end
    endtask

    task automatic test_full_read();
        logic [9:0] exp[$];
        en_mask  = 2'b01;
        o_tready = 2'b00;
        got0.delete();
        got1.delete();
        for (int b = 1; b <= 4; b++) drive_beat(8'(8'hC0 + b), 1'b0, 1'b1);
        i_tvalid = 1'b1;
        i_tdata  = 8'hC5;
        i_tlast  = 1'b1;
        i_tuser  = 1'b1;
        #1;
        checks++;
        if (fifo_level[2:0] !== 3'd4) begin errors++; $display("FAIL full_level: got %0d want 4", fifo_level[2:0]); end
        o_tready = 2'b01;
        #1;
        checks++;
        if (i_tready !== 1'b0) begin errors++; $display("FAIL full_same_cycle: tready %b want 0", i_tready); end
        checks++;
        if (o_tvalid[0] !== 1'b1 || o_tdata[7:0] !== 8'hC1 || o_tuser[0] !== 1'b1) begin
            errors++; $display("FAIL full_head: valid %b data %h user %b want 1 c1 1", o_tvalid[0], o_tdata[7:0], o_tuser[0]);
        end
        @(posedge clk);
        #1;
        checks++;
        if (i_tready !== 1'b1) begin errors++; $display("FAIL full_next_cycle: tready %b want 1", i_tready); end
        drive_beat(8'hC5, 1'b1, 1'b1);
        repeat (8) cyc();
        exp = '{10'h1C1, 10'h1C2, 10'h1C3, 10'h1C4, 10'h3C5};
        checks++;
        if (!same(got0, exp)) begin errors++; $display("FAIL full_order: got %p want %p", got0, exp); end
        checks++;
        if (got1.size() != 0) begin errors++; $display("FAIL full_s1_idle: got %0d beats want 0", got1.size()); end
    endtask

    task automatic test_async_reset();
        logic [9:0] exp[$];
        en_mask  = 2'b11;
        o_tready = 2'b11;
        drive_beat(8'h41, 1'b0, 1'b0);
        i_tvalid = 1'b1;
        i_tdata  = 8'h42;
        #2 aresetn = 1'b0;
        #1;
        checks++;
        if (o_tvalid !== 2'b00 || fifo_level !== 6'd0) begin
            errors++; $display("FAIL areset_out: valid %b level %h want 00 0", o_tvalid, fifo_level);
        end
        checks++;
        if (drop_count !== 16'd0) begin errors++; $display("FAIL areset_drop: got %h want 0", drop_count); end
        checks++;
        if (i_tready !== 1'b0) begin errors++; $display("FAIL areset_tready: got %b want 0", i_tready); end
        i_tvalid = 1'b0;
        repeat (2) @(posedge clk);
        #3 aresetn = 1'b1;
        got0.delete();
        got1.delete();
        cyc();
        drive_beat(8'h51, 1'b0, 1'b0);
        drive_beat(8'h52, 1'b1, 1'b0);
        repeat (4) cyc();
        exp = '{10'h051, 10'h252};
        checks++;
        if (!same(got0, exp)) begin errors++; $display("FAIL areset_s0: got %p want %p", got0, exp); end
        checks++;
        if (!same(got1, exp)) begin errors++; $display("FAIL areset_s1: got %p want %p", got1, exp); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall_isolation();
        test_mask_latch();
        test_drop();
        test_full_read();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
